// File: rtl/jts16_sched_pkg.sv
// jts16_sched_pkg
// Shared definitions for the SDRAM bank scheduler: sequencer state encoding,
// bank index constants, the default refresh interval and a bank-to-strobe
// helper.
package jts16_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_REFRESH = 2'd3
  } sched_state_e;

  localparam logic [1:0] BANK_MAIN  = 2'd0;  // RAM/VRAM/ROM, only writer
  localparam logic [1:0] BANK_SOUND = 2'd1;
  localparam logic [1:0] BANK_TILES = 2'd2;
  localparam logic [1:0] BANK_OBJ   = 2'd3;

  localparam int REF_PERIOD_DEF = 390;

  function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
    bank_onehot = 4'b0001 << bank;
  endfunction

endpackage

// File: rtl/jts16_sched_pick.sv
// jts16_sched_pick
// Winner select among the four bank requests.
//   Macro JTS16_SCHED_RR_EN: defined -> round-robin, search starts at an
//   internal pointer that moves to winner+1 on every accepted command.
//   Undefined -> fixed priority bank 0 > 1 > 2 > 3, no pointer state.
// Ports:
//   clk, rst_n      clock, async active-low reset (pointer only)
//   req[3:0]        pending request per bank
//   adv             pointer update strobe (command accepted)
//   adv_bank        bank that was accepted
//   win, win_vld    selected bank, and whether any request is pending
module jts16_sched_pick
  import jts16_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       adv,
  input  logic [1:0] adv_bank,
  output logic [1:0] win,
  output logic       win_vld
);

`ifdef JTS16_SCHED_RR_EN
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv) ptr_d = adv_bank + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= BANK_MAIN;
    else        ptr_q <= ptr_d;
  end

  // Walk offsets from farthest to nearest so the bank closest to the
  // pointer is the last (winning) assignment.
  always_comb begin
    win     = ptr_q;
    win_vld = |req;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
    end
  end
`else
  logic unused_pick;
  assign unused_pick = &{1'b0, clk, rst_n, adv, adv_bank};

  always_comb begin
    win     = BANK_MAIN;
    win_vld = |req;
    if (req[3]) win = BANK_OBJ;
    if (req[2]) win = BANK_TILES;
    if (req[1]) win = BANK_SOUND;
    if (req[0]) win = BANK_MAIN;
  end
`endif

endmodule

// File: rtl/jts16_bank_sched.sv
// jts16_bank_sched
// Serialises the four bank slot managers onto the single-command SDRAM
// controller, one command in flight, with periodic auto-refresh inserted
// while refresh_en is high. Only bank 0 can write.
// Macro JTS16_SCHED_RR_EN selects round-robin arbitration (see
// jts16_sched_pick); default build is fixed priority.
// Ports:
//   ba_rd/ba0_wr/ba_addr/ba0_din/ba0_din_m   bank-side requests (level)
//   ba_ack/ba_rdy/data_read                   bank-side strobes and data
//   refresh_en                                refresh window
//   cmd_*                                     command to SDRAM controller
//   cmd_gnt/cmd_done/sdram_dout               controller handshake
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no command in flight; refresh first, else pick a bank
// ST_ISSUE   | cmd_req high with latched bank command, waiting cmd_gnt
// ST_WAIT    | bank command granted, waiting cmd_done
// ST_REFRESH | refresh requested (before grant) or in progress (after)
module jts16_bank_sched
  import jts16_sched_pkg::*;
#(
  parameter int AW         = 22,
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int REF_W      = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      ba_rd,
  input  logic            ba0_wr,
  input  logic [4*AW-1:0] ba_addr,
  input  logic [15:0]     ba0_din,
  input  logic [1:0]      ba0_din_m,
  output logic [3:0]      ba_ack,
  output logic [3:0]      ba_rdy,
  output logic [31:0]     data_read,
  input  logic            refresh_en,
  output logic            cmd_req,
  output logic [1:0]      cmd_ba,
  output logic [AW-1:0]   cmd_addr,
  output logic            cmd_wr,
  output logic            cmd_ref,
  output logic [15:0]     cmd_din,
  output logic [1:0]      cmd_mask,
  input  logic            cmd_gnt,
  input  logic            cmd_done,
  input  logic [31:0]     sdram_dout
);

  sched_state_e    state_q, state_d;
  logic [1:0]      win_q, win_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wr_q, wr_d;
  logic [15:0]     din_q, din_d;
  logic [1:0]      mask_q, mask_d;
  logic [3:0]      ack_q, ack_d;
  logic [3:0]      rdy_q, rdy_d;
  logic [31:0]     data_q, data_d;
  logic            refg_q, refg_d;     // refresh granted, waiting done
  logic [REF_W-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            ref_clr;
  logic            ref_hit;

  logic [1:0]      pick_win;
  logic            pick_vld;
  logic [AW-1:0]   pick_addr;
  logic            pick_adv;

  jts16_sched_pick u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (ba_rd | {3'b000, ba0_wr}),
    .adv      (pick_adv),
    .adv_bank (win_q),
    .win      (pick_win),
    .win_vld  (pick_vld)
  );

  assign pick_adv = (state_q == ST_ISSUE) && cmd_gnt;

  always_comb begin
    pick_addr = ba_addr[AW-1:0];
    case (pick_win)
      BANK_SOUND: pick_addr = ba_addr[AW+:AW];
      BANK_TILES: pick_addr = ba_addr[2*AW+:AW];
      BANK_OBJ:   pick_addr = ba_addr[3*AW+:AW];
      default:    ;
    endcase
  end

  // Refresh interval: counts only inside the refresh window; the pending
  // flag is independent of the window so a request is never lost.
  always_comb begin
    ref_hit = refresh_en && (cnt_q == REF_W'(REF_PERIOD - 1));
    cnt_d   = cnt_q;
    if (refresh_en) cnt_d = ref_hit ? '0 : cnt_q + 1'b1;
    pend_d = pend_q;
    if (ref_clr) pend_d = 1'b0;
    if (ref_hit) pend_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    din_d   = din_q;
    mask_d  = mask_q;
    ack_d   = '0;
    rdy_d   = '0;
    data_d  = data_q;
    refg_d  = refg_q;
    ref_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_REFRESH;
          refg_d  = 1'b0;
        end else if (pick_vld) begin
          state_d = ST_ISSUE;
          win_d   = pick_win;
          addr_d  = pick_addr;
          // bank 0 write beats a simultaneous bank 0 read
          wr_d    = (pick_win == BANK_MAIN) && ba0_wr;
          din_d   = ba0_din;
          mask_d  = ba0_din_m;
        end
      end
      ST_ISSUE: begin
        if (cmd_gnt) begin
          ack_d   = bank_onehot(win_q);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cmd_done) begin
          if (!wr_q) data_d = sdram_dout;
          rdy_d   = bank_onehot(win_q);
          state_d = ST_IDLE;
        end
      end
      ST_REFRESH: begin
        if (!refg_q) begin
          if (cmd_gnt) refg_d = 1'b1;
        end else if (cmd_done) begin
          ref_clr = 1'b1;
          refg_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= BANK_MAIN;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      mask_q  <= '0;
      ack_q   <= '0;
      rdy_q   <= '0;
      data_q  <= '0;
      refg_q  <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      refg_q  <= refg_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign cmd_req   = (state_q == ST_ISSUE) || ((state_q == ST_REFRESH) && !refg_q);
  assign cmd_ref   = (state_q == ST_REFRESH);
  assign cmd_ba    = win_q;
  assign cmd_addr  = addr_q;
  assign cmd_wr    = wr_q;
  assign cmd_din   = din_q;
  assign cmd_mask  = mask_q;
  assign ba_ack    = ack_q;
  assign ba_rdy    = rdy_q;
  assign data_read = data_q;

endmodule

// File: tb/tb_jts16_bank_sched.sv
module tb_jts16_bank_sched;

  localparam int AW         = 22;
  localparam int REF_PERIOD = 390;
  localparam int REF_W      = 9;

`ifdef JTS16_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      ba_rd = '0;
  logic            ba0_wr = 1'b0;
  logic [4*AW-1:0] ba_addr;
  logic [15:0]     ba0_din = '0;
  logic [1:0]      ba0_din_m = '0;
  logic [3:0]      ba_ack, ba_rdy;
  logic [31:0]     data_read;
  logic            refresh_en = 1'b0;
  logic            cmd_req, cmd_wr, cmd_ref;
  logic [1:0]      cmd_ba, cmd_mask;
  logic [AW-1:0]   cmd_addr;
  logic [15:0]     cmd_din;
  logic            cmd_gnt = 1'b0, cmd_done = 1'b0;
  logic [31:0]     sdram_dout = '0;

  logic [AW-1:0]   addr_m [4];
  assign ba_addr = {addr_m[3], addr_m[2], addr_m[1], addr_m[0]};

  int n_err = 0;
  int n_chk = 0;
  int mptr = 0;            // model round-robin pointer
  logic [31:0] exp_data = '0;

  // observations recorded by the controller model
  logic          s_to, s_ref, s_wr, s_req_after, s_drop_early;
  logic [1:0]    s_ba, s_mask;
  logic [AW-1:0] s_addr;
  logic [15:0]   s_din;
  logic [3:0]    s_ack, s_rdy;
  logic [31:0]   s_data;
  int            s_acks, s_rdys, s_wait;

  jts16_bank_sched #(.AW(AW), .REF_PERIOD(REF_PERIOD), .REF_W(REF_W)) dut (
    .clk(clk), .rst_n(rst_n), .ba_rd(ba_rd), .ba0_wr(ba0_wr), .ba_addr(ba_addr),
    .ba0_din(ba0_din), .ba0_din_m(ba0_din_m), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
    .data_read(data_read), .refresh_en(refresh_en), .cmd_req(cmd_req), .cmd_ba(cmd_ba),
    .cmd_addr(cmd_addr), .cmd_wr(cmd_wr), .cmd_ref(cmd_ref), .cmd_din(cmd_din),
    .cmd_mask(cmd_mask), .cmd_gnt(cmd_gnt), .cmd_done(cmd_done), .sdram_dout(sdram_dout)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference arbitration: first requesting bank at or after the start
  // position (always 0 for fixed priority).
  function automatic int exp_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; ba_rd = '0; ba0_wr = 1'b0; ba0_din = '0; ba0_din_m = '0;
    refresh_en = 1'b0; cmd_gnt = 1'b0; cmd_done = 1'b0; sdram_dout = '0;
    for (int b = 0; b < 4; b++) addr_m[b] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mptr = 0;
    exp_data = '0;
  endtask

  // SDRAM controller model: waits for a command, grants it after gdly
  // cycles (with a stray cmd_done before the grant), completes it after
  // ddly more cycles. Records what it observed; makes no judgement.
  task automatic serve(input int gdly, input int ddly, input logic [31:0] dout, input bit drop);
    int n;
    s_to = 1'b0; s_acks = 0; s_rdys = 0; s_ack = '0; s_rdy = '0;
    s_req_after = 1'b0; s_drop_early = 1'b0; s_wait = 0;
    n = 0;
    while (!cmd_req && n < 300) begin
      @(negedge clk); n++;
      s_acks += $countones(ba_ack); s_rdys += $countones(ba_rdy);
    end
    s_wait = n;
    if (!cmd_req) begin s_to = 1'b1; return; end
    for (int i = 0; i < gdly; i++) begin
      cmd_done = (i == 0);
      @(negedge clk);
      cmd_done = 1'b0;
      s_acks += $countones(ba_ack); s_rdys += $countones(ba_rdy);
      if (!cmd_req) s_drop_early = 1'b1;
    end
    s_ba = cmd_ba; s_addr = cmd_addr; s_wr = cmd_wr; s_ref = cmd_ref;
    s_din = cmd_din; s_mask = cmd_mask;
    cmd_gnt = 1'b1;
    @(negedge clk);
    cmd_gnt = 1'b0;
    s_ack = ba_ack; s_req_after = cmd_req;
    s_acks += $countones(ba_ack); s_rdys += $countones(ba_rdy);
    if (drop) begin
      if (ba_ack[0]) ba0_wr = 1'b0;
      ba_rd = ba_rd & ~ba_ack;
    end
    repeat (ddly) begin
      @(negedge clk);
      s_acks += $countones(ba_ack); s_rdys += $countones(ba_rdy);
    end
    cmd_done = 1'b1; sdram_dout = dout;
    @(negedge clk);
    cmd_done = 1'b0;
    s_rdy = ba_rdy; s_data = data_read;
    s_acks += $countones(ba_ack); s_rdys += $countones(ba_rdy);
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++; if (cmd_req !== 1'b0) begin n_err++; $display("FAIL reset_cmd_req got %b want 0", cmd_req); end
    n_chk++; if (ba_ack !== 4'b0 || ba_rdy !== 4'b0) begin n_err++; $display("FAIL reset_strobes got ack=%b rdy=%b want 0", ba_ack, ba_rdy); end
    n_chk++; if (data_read !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", data_read); end
    n_chk++; if ({cmd_ba, cmd_addr, cmd_wr, cmd_ref, cmd_din, cmd_mask} !== '0) begin
      n_err++; $display("FAIL reset_cmd_fields got ba=%h addr=%h wr=%b ref=%b din=%h mask=%b want 0",
                        cmd_ba, cmd_addr, cmd_wr, cmd_ref, cmd_din, cmd_mask); end
  endtask

  task automatic test_single_read();
    apply_reset();
    addr_m[2] = 22'h1234; ba_rd[2] = 1'b1;
    serve(2, 3, 32'hDEADBEEF, 1'b1);
    n_chk++; if (s_to !== 1'b0) begin n_err++; $display("FAIL rd_timeout got no cmd_req"); end
    n_chk++; if (s_wait != 1) begin n_err++; $display("FAIL rd_latency got %0d want 1", s_wait); end
    n_chk++; if (s_ba !== 2'd2 || s_addr !== 22'h1234 || s_wr !== 1'b0 || s_ref !== 1'b0) begin
      n_err++; $display("FAIL rd_cmd got ba=%0d addr=%h wr=%b ref=%b want 2 1234 0 0", s_ba, s_addr, s_wr, s_ref); end
    n_chk++; if (s_drop_early !== 1'b0) begin n_err++; $display("FAIL rd_req_held got dropped before gnt"); end
    n_chk++; if (s_ack !== 4'b0100 || s_req_after !== 1'b0) begin
      n_err++; $display("FAIL rd_ack got ack=%b req=%b want 0100 0", s_ack, s_req_after); end
    n_chk++; if (s_rdy !== 4'b0100 || s_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rd_rdy got rdy=%b data=%h want 0100 deadbeef", s_rdy, s_data); end
    n_chk++; if (s_acks != 1 || s_rdys != 1) begin n_err++; $display("FAIL rd_pulses got acks=%0d rdys=%0d want 1 1", s_acks, s_rdys); end
  endtask

  task automatic test_write();
    apply_reset();
    addr_m[0] = 22'h3F00F; ba_rd[0] = 1'b1; ba0_wr = 1'b1; ba0_din = 16'hA55A; ba0_din_m = 2'b01;
    serve(1, 2, 32'h12345678, 1'b1);
    n_chk++; if (s_to !== 1'b0) begin n_err++; $display("FAIL wr_timeout got no cmd_req"); end
    n_chk++; if (s_wr !== 1'b1 || s_din !== 16'hA55A || s_mask !== 2'b01 || s_ba !== 2'd0 || s_addr !== 22'h3F00F) begin
      n_err++; $display("FAIL wr_cmd got wr=%b din=%h mask=%b ba=%0d addr=%h want 1 a55a 01 0 3f00f",
                        s_wr, s_din, s_mask, s_ba, s_addr); end
    n_chk++; if (s_ack !== 4'b0001 || s_rdy !== 4'b0001 || s_acks != 1 || s_rdys != 1) begin
      n_err++; $display("FAIL wr_strobes got ack=%b rdy=%b acks=%0d rdys=%0d want 0001 0001 1 1", s_ack, s_rdy, s_acks, s_rdys); end
    n_chk++; if (s_data !== 32'h0) begin n_err++; $display("FAIL wr_data_read got %h want 0", s_data); end
    repeat (5) @(negedge clk);
    n_chk++; if (cmd_req !== 1'b0) begin n_err++; $display("FAIL wr_no_second_cmd got cmd_req=%b want 0", cmd_req); end
  endtask

  task automatic test_back_to_back();
    int w;
    apply_reset();
    for (int b = 0; b < 4; b++) addr_m[b] = AW'(32'h100 * (b + 1));
    ba_rd = 4'hF;
    for (int t = 0; t < 8; t++) begin
      w = exp_pick(4'hF, RR ? mptr : 0);
      serve(0, 1, 32'hB0B0_0000 + 32'(t), 1'b0);
      n_chk++; if (s_to !== 1'b0 || s_ba !== 2'(w) || s_addr !== addr_m[w]) begin
        n_err++; $display("FAIL b2b_order[%0d] got ba=%0d addr=%h to=%b want %0d %h", t, s_ba, s_addr, s_to, w, addr_m[w]); end
      n_chk++; if (s_ack !== (4'b0001 << w) || s_rdy !== (4'b0001 << w)) begin
        n_err++; $display("FAIL b2b_strobes[%0d] got ack=%b rdy=%b want bank %0d", t, s_ack, s_rdy, w); end
      if (RR) mptr = (w + 1) % 4;
    end
    ba_rd = '0;
  endtask

  task automatic test_random();
    logic [3:0] r, oh;
    logic ew;
    logic [AW-1:0] ea;
    logic [15:0] ed;
    logic [1:0] em;
    logic [31:0] dv;
    int w, bb;
    apply_reset();
    for (int it = 0; it < 24; it++) begin
      for (int b = 1; b < 4; b++)
        if (!ba_rd[b] && $urandom_range(0, 1) == 1) begin ba_rd[b] = 1'b1; addr_m[b] = AW'($urandom); end
      if (!ba_rd[0] && !ba0_wr && $urandom_range(0, 1) == 1) begin
        ba_rd[0] = 1'($urandom_range(0, 1));
        ba0_wr = !ba_rd[0] || ($urandom_range(0, 1) == 1);
        addr_m[0] = AW'($urandom); ba0_din = 16'($urandom); ba0_din_m = 2'($urandom);
      end
      if ((ba_rd | {3'b000, ba0_wr}) == 4'b0) begin
        bb = $urandom_range(1, 3); ba_rd[bb] = 1'b1; addr_m[bb] = AW'($urandom);
      end
      r  = ba_rd | {3'b000, ba0_wr};
      w  = exp_pick(r, RR ? mptr : 0);
      ew = (w == 0) && ba0_wr;
      ea = addr_m[w]; ed = ba0_din; em = ba0_din_m;
      oh = 4'b0001 << w;
      dv = $urandom;
      serve($urandom_range(0, 3), $urandom_range(0, 4), dv, 1'b1);
      if (!ew) exp_data = dv;
      n_chk++; if (s_to !== 1'b0 || s_ba !== 2'(w) || s_addr !== ea || s_wr !== ew) begin
        n_err++; $display("FAIL rnd_cmd[%0d] got ba=%0d addr=%h wr=%b to=%b want %0d %h %b (req=%b)",
                          it, s_ba, s_addr, s_wr, s_to, w, ea, ew, r); end
      if (ew) begin
        n_chk++; if (s_din !== ed || s_mask !== em) begin
          n_err++; $display("FAIL rnd_wdata[%0d] got din=%h mask=%b want %h %b", it, s_din, s_mask, ed, em); end
      end
      n_chk++; if (s_ack !== oh || s_rdy !== oh || s_acks != 1 || s_rdys != 1 || s_req_after !== 1'b0 || s_drop_early !== 1'b0) begin
        n_err++; $display("FAIL rnd_strobes[%0d] got ack=%b rdy=%b acks=%0d rdys=%0d req=%b early=%b want %b %b 1 1 0 0",
                          it, s_ack, s_rdy, s_acks, s_rdys, s_req_after, s_drop_early, oh, oh); end
      n_chk++; if (s_data !== exp_data) begin n_err++; $display("FAIL rnd_data[%0d] got %h want %h", it, s_data, exp_data); end
      if (RR) mptr = (w + 1) % 4;
    end
  endtask

  task automatic test_withdraw();
    int n;
    apply_reset();
    addr_m[3] = 22'h2ABCD; ba_rd[3] = 1'b1;
    n = 0;
    while (!cmd_req && n < 50) begin @(negedge clk); n++; end
    n_chk++; if (cmd_req !== 1'b1) begin n_err++; $display("FAIL wd_timeout got cmd_req=%b want 1", cmd_req); end
    ba_rd[3] = 1'b0; addr_m[3] = 22'h11111;
    repeat (2) @(negedge clk);
    n_chk++; if (cmd_req !== 1'b1 || cmd_ba !== 2'd3 || cmd_addr !== 22'h2ABCD) begin
      n_err++; $display("FAIL wd_latched got req=%b ba=%0d addr=%h want 1 3 2abcd", cmd_req, cmd_ba, cmd_addr); end
    cmd_gnt = 1'b1; @(negedge clk); cmd_gnt = 1'b0;
    n_chk++; if (ba_ack !== 4'b1000) begin n_err++; $display("FAIL wd_ack got %b want 1000", ba_ack); end
    @(negedge clk);
    cmd_done = 1'b1; sdram_dout = 32'h600DF00D; @(negedge clk); cmd_done = 1'b0;
    n_chk++; if (ba_rdy !== 4'b1000 || data_read !== 32'h600DF00D) begin
      n_err++; $display("FAIL wd_rdy got rdy=%b data=%h want 1000 600df00d", ba_rdy, data_read); end
  endtask

  task automatic test_refresh_during_read();
    apply_reset();
    refresh_en = 1'b1;
    addr_m[1] = 22'h00777; ba_rd[1] = 1'b1;
    addr_m[2] = 22'h00888; ba_rd[2] = 1'b1;
    serve(1, REF_PERIOD + 5, 32'h0BADCAFE, 1'b1);
    refresh_en = 1'b0;
    n_chk++; if (s_to !== 1'b0 || s_ba !== 2'd1 || s_ref !== 1'b0 || s_rdy !== 4'b0010 || s_data !== 32'h0BADCAFE) begin
      n_err++; $display("FAIL rr_first got ba=%0d ref=%b rdy=%b data=%h want 1 0 0010 0badcafe", s_ba, s_ref, s_rdy, s_data); end
    serve(2, 3, 32'hFFFF0000, 1'b1);
    n_chk++; if (s_to !== 1'b0 || s_ref !== 1'b1 || s_acks != 0 || s_rdys != 0 || s_req_after !== 1'b0) begin
      n_err++; $display("FAIL rr_refresh got ref=%b acks=%0d rdys=%0d req=%b to=%b want 1 0 0 0 0",
                        s_ref, s_acks, s_rdys, s_req_after, s_to); end
    n_chk++; if (data_read !== 32'h0BADCAFE) begin n_err++; $display("FAIL rr_data_kept got %h want 0badcafe", data_read); end
    serve(0, 1, 32'h13579BDF, 1'b1);
    n_chk++; if (s_to !== 1'b0 || s_ba !== 2'd2 || s_ref !== 1'b0 || s_addr !== 22'h00888 || s_data !== 32'h13579BDF) begin
      n_err++; $display("FAIL rr_next_read got ba=%0d ref=%b addr=%h data=%h want 2 0 888 13579bdf", s_ba, s_ref, s_addr, s_data); end
  endtask

  task automatic test_refresh_count();
    int en;
    bit early, late;
    apply_reset();
    en = 0; early = 0; late = 0;
    refresh_en = 1'b1;
    repeat (200) begin @(negedge clk); en++; if (cmd_req) early = 1; end
    refresh_en = 1'b0;
    repeat (37) begin @(negedge clk); if (cmd_req) early = 1; end
    refresh_en = 1'b1;
    while (en < REF_PERIOD) begin @(negedge clk); en++; if (cmd_req) early = 1; end
    refresh_en = 1'b0;
    n_chk++; if (early) begin n_err++; $display("FAIL rc_early got refresh before %0d enabled cycles", REF_PERIOD); end
    @(negedge clk);
    n_chk++; if (cmd_req !== 1'b1 || cmd_ref !== 1'b1) begin
      n_err++; $display("FAIL rc_pending got req=%b ref=%b want 1 1", cmd_req, cmd_ref); end
    serve(2, 2, 32'h0, 1'b1);
    n_chk++; if (s_ref !== 1'b1 || s_acks != 0 || s_rdys != 0 || s_drop_early !== 1'b0) begin
      n_err++; $display("FAIL rc_serve got ref=%b acks=%0d rdys=%0d early=%b want 1 0 0 0", s_ref, s_acks, s_rdys, s_drop_early); end
    repeat (50) begin @(negedge clk); if (cmd_req) late = 1; end
    n_chk++; if (late) begin n_err++; $display("FAIL rc_cleared got extra refresh want none"); end
  endtask

  task automatic test_reset_in_wait();
    int n;
    bit bad;
    apply_reset();
    addr_m[1] = 22'h0ABCD; ba_rd[1] = 1'b1;
    serve(1, 1, 32'hCAFE1234, 1'b1);
    n_chk++; if (s_data !== 32'hCAFE1234) begin n_err++; $display("FAIL rw_first got %h want cafe1234", s_data); end
    addr_m[1] = 22'h0DCBA; ba_rd[1] = 1'b1;
    n = 0;
    while (!cmd_req && n < 50) begin @(negedge clk); n++; end
    cmd_gnt = 1'b1; @(negedge clk); cmd_gnt = 1'b0; ba_rd[1] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (cmd_req !== 1'b0 || ba_ack !== 4'b0 || ba_rdy !== 4'b0 || data_read !== 32'h0 || cmd_ba !== 2'd0 || cmd_addr !== '0) begin
      n_err++; $display("FAIL rw_async got req=%b ack=%b rdy=%b data=%h ba=%0d addr=%h want all 0",
                        cmd_req, ba_ack, ba_rdy, data_read, cmd_ba, cmd_addr); end
    @(negedge clk);
    cmd_done = 1'b1; @(negedge clk); cmd_done = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin @(negedge clk); if (ba_rdy !== 4'b0 || cmd_req !== 1'b0) bad = 1; end
    n_chk++; if (bad) begin n_err++; $display("FAIL rw_no_rdy got strobe or command after reset release"); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_random();
    test_withdraw();
    test_refresh_during_read();
    test_refresh_count();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jts16_bank_sched.md
# jts16_bank_sched

Sequencer that sits between the four per-bank slot managers (bank 0 RAM/VRAM/ROM, bank 1 sound, bank 2 tiles, bank 3 objects) and the single-command SDRAM controller. It accepts at most one read or write at a time, inserts auto-refresh requests at a fixed interval, and returns per-bank ack/rdy strobes with the shared read data. Only bank 0 may write.

## Interface
Parameters:
- AW, 22, SDRAM word address width per bank
- REF_PERIOD, 390, clocks between refresh requests while refresh is allowed
- REF_W, 9, width of refresh interval counter (must hold REF_PERIOD)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ba_rd  in  4  read request per bank, level, held until ack
- ba0_wr  in  1  bank 0 write request, level, held until ack
- ba_addr  in  4*AW  concatenated addresses, bank n at [n*AW+:AW]
- ba0_din  in  16  write data
- ba0_din_m  in  2  write byte mask, active high = masked
- ba_ack  out  4  one-cycle strobe: request accepted, address may change
- ba_rdy  out  4  one-cycle strobe: data_read valid (write: write complete)
- data_read  out  32  registered read data
- refresh_en  in  1  refresh allowed window (LVBL)
- cmd_req  out  1  command valid to SDRAM controller
- cmd_ba  out  2  bank of command
- cmd_addr  out  AW  address of command
- cmd_wr  out  1  1 = write
- cmd_ref  out  1  1 = auto-refresh (cmd_addr/cmd_wr ignored)
- cmd_din  out  16  write data
- cmd_mask  out  2  write mask
- cmd_gnt  in  1  controller accepted command (one cycle)
- cmd_done  in  1  controller finished command; sdram_dout valid for reads
- sdram_dout  in  32  raw read data

## Operation
- States: IDLE, ISSUE, WAIT, REFRESH.
- IDLE: if refresh pending -> REFRESH. Else if any request (ba_rd | {3'b0,ba0_wr}) -> pick winner, latch bank/addr/wr/din/mask, -> ISSUE. Else stay.
- ISSUE: cmd_req=1 with latched fields; on cmd_gnt pulse ba_ack[winner], -> WAIT.
- WAIT: on cmd_done latch sdram_dout into data_read (reads only), pulse ba_rdy[winner] next cycle, -> IDLE.
- REFRESH: cmd_req=1, cmd_ref=1; on cmd_gnt -> WAIT-like hold until cmd_done, clear pending, -> IDLE. No ba_ack/ba_rdy.
- Refresh counter counts up while refresh_en=1, saturates nothing: on reaching REF_PERIOD-1 sets pending and wraps to 0. Counter holds when refresh_en=0; pending, once set, survives refresh_en falling.
- Bank 0 with both ba_rd[0] and ba0_wr high: write wins.
- Winner selection per Configuration. Requests withdrawn while in ISSUE are still completed (latched copy used); rdy still pulses.
- cmd_done in ISSUE (before gnt) is a protocol violation; ignored.

## Timing
- Reset: state IDLE, all outputs 0, data_read 0, counter 0, pending 0, round-robin pointer 0.
- Request in IDLE at cycle t -> cmd_req at t+1.
- ba_ack coincides with cycle after cmd_gnt (registered); cmd_req drops same cycle.
- cmd_done at cycle d -> data_read and ba_rdy valid at d+1, IDLE at d+1, next cmd_req no earlier than d+2.
- Refresh pending set in same cycle as a new request: refresh wins.
- rst_n assertion mid-transaction aborts immediately; no strobes issued.

## Configuration
- JTS16_SCHED_RR_EN defined: round-robin among banks; pointer advances to winner+1 after each ack, search starts at pointer.
- Undefined: fixed priority bank 0 > 1 > 2 > 3; pointer logic absent.

## Structure
- Shared package jts16_sched_pkg: state enum (IDLE, ISSUE, WAIT, REFRESH), bank index constants, REF_PERIOD default.
- One sub-module natural: jts16_sched_pick (4-input winner select, fixed or round-robin, combinational plus pointer register).

## Test plan
- Single read bank 2 addr 0x1234, sdram_dout 0xDEADBEEF -> cmd_ba=2, cmd_addr=0x1234, ba_ack[2] pulse, data_read=0xDEADBEEF with ba_rdy[2].
- Bank 0 write din 0xA55A mask 2'b01 with ba_rd[0] also high -> cmd_wr=1, cmd_din=0xA55A, cmd_mask=01, one ack/rdy only.
- All four ba_rd held high, 8 transactions -> RR build: order 0,1,2,3,0,1,2,3; fixed build: bank 0 only.
- refresh_en=1 for REF_PERIOD cycles during pending read -> read completes, then cmd_ref=1 issued before next read.
- refresh_en toggled low at count 200 then high -> refresh pending exactly REF_PERIOD enabled cycles after start.
- rst_n low during WAIT -> all outputs 0 asynchronously, no ba_rdy after release.
